// File: rtl/vector_ram_responder.sv
// vector_ram_responder: memory-side responder for the SIMD core's vector
// data-RAM port. Holds DEPTH x DATA_W words of storage, commits byte-enabled
// writes in one cycle and returns reads READ_LAT cycles after acceptance,
// stalling the core while a read is in flight.
//
// Optional feature, macro RAM_ADDR_CHECK_EN:
//   defined   - requests with address_RAM >= DEPTH drop writes, return zero
//               read data with normal timing, and set the sticky addr_err.
//   undefined - addresses wrap modulo DEPTH and addr_err is tied low.
module vector_ram_responder #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 256,
  parameter int DEPTH    = 1024,  // must be a power of two
  parameter int READ_LAT = 2      // 1..7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address_RAM,
  input  logic [DATA_W/8-1:0]   byteena_RAM,
  input  logic [DATA_W-1:0]     writeData_RAM,
  input  logic                  rden_RAM,
  input  logic                  wren_RAM,
  output logic [DATA_W-1:0]     readData_RAM,
  output logic                  rvalid,
  output logic                  stall,
  output logic                  addr_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RWAIT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic               oor_q;

  logic [IDX_W-1:0]   idx_now;
  logic               oor_now;
  logic               accept_rd;
  logic               wr_fire;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  cur_word;
  logic [DATA_W-1:0]  merged_word;
  logic [DATA_W-1:0]  rd_word;
  logic               rd_zero;

  assign idx_now = address_RAM[IDX_W-1:0];

`ifdef RAM_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  assign oor_now = ({1'b0, address_RAM} >= DEPTH_LIM);
`else
  // Upper address bits only matter for the range check; here they alias away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address_RAM[ADDR_W-1:IDX_W];
  assign oor_now        = 1'b0;
`endif

  // Requests are only taken in IDLE; anything held during a stall is ignored.
  assign accept_rd = (state_q == IDLE) && rden_RAM;
  assign wr_fire   = (state_q == IDLE) && wren_RAM && !oor_now;

  // Next-state and counter logic for the read-latency FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rden_RAM) begin
          cnt_d   = CNT_W'(READ_LAT - 1);
          state_d = (READ_LAT == 1) ? RESP : RWAIT;
        end
      end
      RWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and latched read address.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_rd) begin
        idx_q <= idx_now;
        oor_q <= oor_now;
      end
    end
  end

  // Byte-lane merge of the write data into the addressed word; also used as
  // the write-first bypass when READ_LAT=1 captures data at the write edge.
  always_comb begin
    cur_word    = mem[idx_now];
    merged_word = cur_word;
    for (int i = 0; i < BE_W; i++) begin
      if (byteena_RAM[i]) merged_word[8*i +: 8] = writeData_RAM[8*i +: 8];
    end
    if (state_q == IDLE) begin
      rd_word = wr_fire ? merged_word : cur_word;
      rd_zero = oor_now;
    end else begin
      rd_word = mem[idx_q];
      rd_zero = oor_q;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; contents survive reset and this
    // lets it map onto block RAM.
    if (wr_fire) mem[idx_now] <= merged_word;
  end

  // Read data register, loaded on the edge entering RESP and held afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readData_RAM <= '0;
    end else if (state_d == RESP) begin
      readData_RAM <= rd_zero ? '0 : rd_word;
    end
  end

`ifdef RAM_ADDR_CHECK_EN
  // Sticky out-of-range flag, set on any accepted out-of-range request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if ((state_q == IDLE) && (rden_RAM || wren_RAM) && oor_now) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

  // Stall covers the request cycle and the wait; it drops in RESP so the core
  // captures the data and advances on the following edge.
  assign rvalid = (state_q == RESP);
  assign stall  = (state_q == RWAIT) || ((state_q == IDLE) && rden_RAM);

endmodule

// File: tb/tb_vector_ram_responder.sv
// tb_vector_ram_responder: directed and randomized checks of
// vector_ram_responder against a word-array reference model. Honours
// RAM_ADDR_CHECK_EN the same way the design does.
module tb_vector_ram_responder;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 256;
  localparam int DEPTH    = 1024;
  localparam int READ_LAT = 2;
  localparam int BE_W     = DATA_W / 8;
  localparam int TCLK     = 10;

`ifdef RAM_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [ADDR_W-1:0]   address_RAM;
  logic [BE_W-1:0]     byteena_RAM;
  logic [DATA_W-1:0]   writeData_RAM;
  logic                rden_RAM;
  logic                wren_RAM;
  logic [DATA_W-1:0]   readData_RAM;
  logic                rvalid;
  logic                stall;
  logic                addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                exp_err;
  time               pulse_t[$];

  vector_ram_responder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address_RAM   (address_RAM),
    .byteena_RAM   (byteena_RAM),
    .writeData_RAM (writeData_RAM),
    .rden_RAM      (rden_RAM),
    .wren_RAM      (wren_RAM),
    .readData_RAM  (readData_RAM),
    .rvalid        (rvalid),
    .stall         (stall),
    .addr_err      (addr_err)
  );

  always #(TCLK/2) clk = ~clk;

  // Timestamp every rvalid pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rvalid === 1'b1) pulse_t.push_back($time);
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_oor(input int a);
    return CHECK_EN && (a >= DEPTH);
  endfunction

  task automatic model_write(input int a, input logic [DATA_W-1:0] d,
                             input logic [BE_W-1:0] be);
    if (is_oor(a)) return;
    for (int i = 0; i < BE_W; i++)
      if (be[i]) ref_mem[a % DEPTH][8*i +: 8] = d[8*i +: 8];
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int a);
    return is_oor(a) ? '0 : ref_mem[a % DEPTH];
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W/32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // ---------------- bus operations (start and end at posedge+1) ----------------
  task automatic do_write(input string tag, input int a, input logic [DATA_W-1:0] d,
                          input logic [BE_W-1:0] be);
    address_RAM   = ADDR_W'(a);
    writeData_RAM = d;
    byteena_RAM   = be;
    wren_RAM      = 1'b1;
    #1;
    check({tag, "_stall"}, stall, 1'b0);
    @(posedge clk); #1;
    wren_RAM = 1'b0;
    model_write(a, d, be);
    if (is_oor(a)) exp_err = 1'b1;
  endtask

  task automatic do_read(input string tag, input int a, input bit with_wr,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] exp;
    int n;
    bit seen;
    address_RAM   = ADDR_W'(a);
    writeData_RAM = d;
    byteena_RAM   = be;
    rden_RAM      = 1'b1;
    wren_RAM      = with_wr;
    if (with_wr) model_write(a, d, be);
    if (is_oor(a)) exp_err = 1'b1;
    exp = model_read(a);
    #1;
    check({tag, "_stall_req"}, stall, 1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (rvalid === 1'b1) seen = 1'b1;
      else check({tag, "_stall_wait"}, stall, 1'b1);
    end
    check({tag, "_latency"}, n, READ_LAT);
    check({tag, "_data"}, readData_RAM, exp);
    check({tag, "_stall_resp"}, stall, 1'b0);
    @(posedge clk); #1;
    rden_RAM = 1'b0;
    wren_RAM = 1'b0;
    check({tag, "_pulse_end"}, rvalid, 1'b0);
    check({tag, "_data_hold"}, readData_RAM, exp);
  endtask

  initial begin
    int n0;
    int a;
    int op;

    reset = 1'b0;
    address_RAM = '0;
    byteena_RAM = '0;
    writeData_RAM = '0;
    rden_RAM = 1'b0;
    wren_RAM = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state.
    #1;
    check("rst_rdata", readData_RAM, '0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Full write then read at addr 5.
    do_write("w5", 5, 256'h1FF, '1);
    do_read("r5", 5, 1'b0, '0, '0);

    // Partial byte-enable overwrite at addr 9.
    do_write("w9a", 9, {32{8'hAA}}, '1);
    do_write("w9b", 9, {32{8'h55}}, 32'h0000_0001);
    do_read("r9", 9, 1'b0, '0, '0);
    check("r9_exact", readData_RAM, {{31{8'hAA}}, 8'h55});

    // Simultaneous read and write: write-first.
    do_read("rw3", 3, 1'b1, 256'h1234, '1);
    check("rw3_exact", readData_RAM, 256'h1234);

    // Pre-fill a small address window with random data.
    for (int i = 0; i < 16; i++) do_write("fill", i, rand_word(), '1);

    // Reset in the middle of a read.
    n0 = pulse_t.size();
    address_RAM = ADDR_W'(7);
    rden_RAM = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rden_RAM = 1'b0;
    exp_err = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_rdata", readData_RAM, '0);
    check("mid_rst_stall", stall, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_pulse", pulse_t.size() - n0, 0);
    do_read("r7_after_rst", 7, 1'b0, '0, '0);

    // Back-to-back reads with the request held through the stall.
    n0 = pulse_t.size();
    do_read("b2b_1", 1, 1'b0, '0, '0);
    do_read("b2b_2", 2, 1'b0, '0, '0);
    check("b2b_pulse_count", pulse_t.size() - n0, 2);
    if (pulse_t.size() >= n0 + 2)
      check("b2b_spacing", pulse_t[n0+1] - pulse_t[n0], (READ_LAT + 1) * TCLK);

    // Address DEPTH: aliases to 0, or is rejected with addr_err.
    do_write("w_oor", DEPTH, {32{8'hC3}}, '1);
    check("oor_err_w", addr_err, exp_err);
    do_read("r_oor", DEPTH, 1'b0, '0, '0);
    check("oor_err_r", addr_err, exp_err);
    do_read("r_addr0", 0, 1'b0, '0, '0);
    check("oor_err_sticky", addr_err, exp_err);

    // Randomized mix of writes, reads and combined accesses.
    for (int k = 0; k < 40; k++) begin
      a  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) a = a + DEPTH * $urandom_range(1, 3);
      op = $urandom_range(0, 2);
      case (op)
        0:       do_write("rnd_w", a, rand_word(), ($urandom | 32'h0));
        1:       do_read("rnd_r", a, 1'b0, '0, '0);
        default: do_read("rnd_rw", a, 1'b1, rand_word(), $urandom);
      endcase
      check("rnd_addr_err", addr_err, exp_err);
    end

    // Final sweep of the window against the model.
    for (int i = 0; i < 16; i++) do_read("sweep", i, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
